// File: rtl/sync_tree_arb.sv
// Clocked M-to-1 level-handshake arbiter with round-robin or fixed-priority selection.
// Grants are held until the owner withdraws, and every handover passes through an all-zero cycle.
module sync_tree_arb #(
    parameter int MR        = 4,
    parameter int PRIO_MODE = 0,
    localparam int IW       = (MR > 1) ? $clog2(MR) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [MR-1:0] req,
    output logic [MR-1:0] gnt,
    output logic          gnt_vld,
    output logic [IW-1:0] gnt_idx
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [MR-1:0] gnt_q, gnt_d;
    logic          vld_q, vld_d;

    logic [IW-1:0] win;
    logic [IW-1:0] candIdx;
    logic          found;
    int            cand;

    // Search starts at the pointer in round-robin mode and at index 0 in fixed-priority mode.
    always_comb begin
        win     = '0;
        found   = 1'b0;
        cand    = 0;
        candIdx = '0;
        for (int k = 0; k < MR; k++) begin
            if (PRIO_MODE == 1) begin
                cand = k;
            end else begin
                cand = (int'(ptr_q) + k) % MR;
            end
            candIdx = IW'(cand);
            if (!found && req[candIdx]) begin
                found = 1'b1;
                win   = candIdx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        gnt_d   = gnt_q;
        vld_d   = vld_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d    = GRANT;
                    gnt_d      = '0;
                    gnt_d[win] = 1'b1;
                    idx_d      = win;
                    vld_d      = 1'b1;
                    if (PRIO_MODE == 0) begin
                        ptr_d = (int'(win) == MR - 1) ? '0 : IW'(int'(win) + 1);
                    end
                end
            end
            GRANT: begin
                // Only the owner's level matters here; returning to IDLE forces the zero cycle.
                if (!req[idx_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    idx_d   = '0;
                    vld_d   = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            vld_q   <= vld_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_vld = vld_q;
    assign gnt_idx = idx_q;

endmodule

// File: tb/tb_sync_tree_arb.sv
// Bench for sync_tree_arb: a round-robin and a fixed-priority instance side by side,
// checked cycle by cycle against a behavioural arbiter model plus directed ordering checks.
module tb_sync_tree_arb;

    typedef struct packed {
        logic [3:0] gnt;
        logic       vld;
        logic [1:0] idx;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] reqRr, reqFp;
    logic [3:0] gntRr, gntFp;
    logic       gntVldRr, gntVldFp;
    logic [1:0] gntIdxRr, gntIdxFp;

    int checks = 0;
    int passed = 0;

    exp_t expRr[$];
    exp_t expFp[$];
    int   grantsRr[$];
    int   grantsFp[$];

    int ownerRr = -1, ptrRr = 0;
    int ownerFp = -1, ptrFp = 0;

    sync_tree_arb #(.MR(4), .PRIO_MODE(0)) dutRr (
        .clk(clk), .rst_n(rst_n), .req(reqRr),
        .gnt(gntRr), .gnt_vld(gntVldRr), .gnt_idx(gntIdxRr)
    );

    sync_tree_arb #(.MR(4), .PRIO_MODE(1)) dutFp (
        .clk(clk), .rst_n(rst_n), .req(reqFp),
        .gnt(gntFp), .gnt_vld(gntVldFp), .gnt_idx(gntIdxFp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic checkZero(input string name);
        checkOutput({name, "Rr"}, int'({gntRr, gntVldRr, gntIdxRr}), 0);
        checkOutput({name, "Fp"}, int'({gntFp, gntVldFp, gntIdxFp}), 0);
    endtask

    task automatic applyStimulus(input logic [3:0] rr, input logic [3:0] fp);
        @(negedge clk);
        reqRr = rr;
        reqFp = fp;
    endtask

    // Arbiter behaviour straight from the rules: owner keeps the grant while requesting,
    // release always costs one idle cycle, and a new winner is chosen only from idle.
    function automatic exp_t modelStep(inout int owner, inout int ptr,
                                       input logic [3:0] r, input bit fixedPrio);
        exp_t e;
        int   w;
        int   c;
        if (owner >= 0) begin
            if (!r[owner]) owner = -1;
        end else if (r != 4'b0) begin
            w = -1;
            for (int k = 0; k < 4; k++) begin
                c = fixedPrio ? k : (ptr + k) % 4;
                if (w < 0 && r[c]) w = c;
            end
            owner = w;
            if (!fixedPrio) ptr = (w + 1) % 4;
        end
        e.gnt = (owner >= 0) ? 4'(1 << owner) : 4'b0;
        e.vld = (owner >= 0);
        e.idx = (owner >= 0) ? 2'(owner) : 2'b0;
        return e;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                ownerRr = -1; ptrRr = 0;
                ownerFp = -1; ptrFp = 0;
                expRr.delete();
                expFp.delete();
            end else begin
                expRr.push_back(modelStep(ownerRr, ptrRr, reqRr, 1'b0));
                expFp.push_back(modelStep(ownerFp, ptrFp, reqFp, 1'b1));
            end
        end
    end

    // Monitor: every registered output cycle is compared against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && expRr.size() > 0) begin
                e = expRr.pop_front();
                checkOutput("scoreboardRr", int'({gntRr, gntVldRr, gntIdxRr}), int'(e));
            end
            if (rst_n && expFp.size() > 0) begin
                e = expFp.pop_front();
                checkOutput("scoreboardFp", int'({gntFp, gntVldFp, gntIdxFp}), int'(e));
            end
        end
    end

    // Each owner drops its request two cycles into the grant and re-raises it once the grant clears.
    task automatic runFairness(input logic [3:0] maskRr, input logic [3:0] maskFp,
                               input int needRr, input int needFp);
        int cntRr = 0, cntFp = 0, zeroRr = 0, zeroFp = 0;
        bit prevRr = 1'b0, prevFp = 1'b0;
        grantsRr.delete();
        grantsFp.delete();
        for (int cyc = 0; cyc < 80 && (grantsRr.size() < needRr || grantsFp.size() < needFp); cyc++) begin
            @(negedge clk);
            if (gntVldRr) begin
                if (!prevRr) begin
                    if (grantsRr.size() > 0) checkOutput("gapRr", zeroRr, 1);
                    grantsRr.push_back(int'(gntIdxRr));
                end
                cntRr++;
                if (cntRr == 2) reqRr[gntIdxRr] = 1'b0;
                zeroRr = 0;
            end else begin
                cntRr = 0;
                zeroRr++;
                reqRr = maskRr;
            end
            prevRr = gntVldRr;
            if (gntVldFp) begin
                if (!prevFp) begin
                    if (grantsFp.size() > 0) checkOutput("gapFp", zeroFp, 1);
                    grantsFp.push_back(int'(gntIdxFp));
                end
                cntFp++;
                if (cntFp == 2) reqFp[gntIdxFp] = 1'b0;
                zeroFp = 0;
            end else begin
                cntFp = 0;
                zeroFp++;
                reqFp = maskFp;
            end
            prevFp = gntVldFp;
        end
        checkOutput("fairnessCountRr", (grantsRr.size() >= needRr) ? needRr : grantsRr.size(), needRr);
        checkOutput("fairnessCountFp", (grantsFp.size() >= needFp) ? needFp : grantsFp.size(), needFp);
        applyStimulus(4'b0, 4'b0);
        repeat (3) @(negedge clk);
    endtask

    task automatic grantCheck(input string name, input logic [3:0] r, input int expIdx);
        applyStimulus(r, 4'b0);
        @(negedge clk);
        checkOutput({name, "Gnt"}, int'(gntRr), 1 << expIdx);
        checkOutput({name, "Idx"}, int'(gntIdxRr), expIdx);
        applyStimulus(4'b0, 4'b0);
        @(negedge clk);
        checkOutput({name, "Release"}, int'({gntRr, gntVldRr}), 0);
    endtask

    initial begin
        int orderRr[6] = '{0, 1, 2, 3, 0, 1};

        rst_n = 1'b1;
        reqRr = 4'b1111;
        reqFp = 4'b1111;
        #2 rst_n = 1'b0;
        #1 checkZero("resetImmediate");
        repeat (3) begin
            @(negedge clk);
            checkZero("resetHeld");
        end
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("firstGrantRr", int'({gntRr, gntIdxRr}), int'({4'b0001, 2'd0}));
        checkOutput("firstGrantFp", int'({gntFp, gntIdxFp}), int'({4'b0001, 2'd0}));
        #2 rst_n = 1'b0;
        #1 checkZero("midGrantReset");
        reqRr = 4'b0;
        reqFp = 4'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        runFairness(4'b1111, 4'b1111, 6, 3);
        for (int i = 0; i < 6; i++) begin
            if (i < grantsRr.size()) checkOutput($sformatf("orderRr%0d", i), grantsRr[i], orderRr[i]);
        end
        for (int i = 0; i < 3; i++) begin
            if (i < grantsFp.size()) checkOutput($sformatf("orderFp%0d", i), grantsFp[i], 0);
        end
        runFairness(4'b1111, 4'b1110, 0, 3);
        for (int i = 0; i < 3; i++) begin
            if (i < grantsFp.size()) checkOutput($sformatf("orderFpNo0_%0d", i), grantsFp[i], 1);
        end

        grantCheck("single", 4'b0100, 2);
        grantCheck("wrapA", 4'b1000, 3);
        grantCheck("wrapB", 4'b0110, 1);
        grantCheck("wrapC", 4'b1001, 3);

        applyStimulus(4'b0010, 4'b0);
        @(negedge clk);
        checkOutput("holdStart", int'(gntRr), 4'b0010);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(4'($urandom) | 4'b0010, 4'b0);
            checkOutput($sformatf("hold%0d", i), int'({gntRr, gntIdxRr}), int'({4'b0010, 2'd1}));
        end
        #2 rst_n = 1'b0;
        #1 checkZero("holdReset");
        reqRr = 4'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        grantCheck("postReset", 4'b1000, 3);
        grantCheck("ptrZero", 4'b1111, 0);

        repeat (400) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) reqRr = 4'($urandom);
            if ($urandom_range(0, 3) == 0) reqFp = 4'($urandom);
        end
        applyStimulus(4'b0, 4'b0);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
